// File: rtl/binary_aggregator_pipe_if.sv
// Round-level handshake bundle for binary_aggregator_pipe: candidate set in, winner out.
// slave is the aggregator's view, master is the producer/consumer side.
interface binary_aggregator_pipe_if #(
  parameter int CANDIDATE_CNT = 5,
  parameter int KEY_WIDTH     = 6,
  parameter int DATA_WIDTH    = 16
);
  localparam int LEVEL_CNT = $clog2(CANDIDATE_CNT);
  localparam int IDX_W     = (LEVEL_CNT > 1) ? LEVEL_CNT : 1;

  logic                     in_vld;
  logic                     in_ready;
  logic [CANDIDATE_CNT-1:0] candidate_vld;
  logic [KEY_WIDTH-1:0]     candidate_key  [CANDIDATE_CNT];
  logic [DATA_WIDTH-1:0]    candidate_data [CANDIDATE_CNT];
  logic                     out_vld;
  logic                     out_ready;
  logic                     winner_hit;
  logic [IDX_W-1:0]         winner_idx;
  logic [KEY_WIDTH-1:0]     winner_key;
  logic [DATA_WIDTH-1:0]    winner_data;

  modport slave (
    input  in_vld, candidate_vld, candidate_key, candidate_data, out_ready,
    output in_ready, out_vld, winner_hit, winner_idx, winner_key, winner_data
  );

  modport master (
    output in_vld, candidate_vld, candidate_key, candidate_data, out_ready,
    input  in_ready, out_vld, winner_hit, winner_idx, winner_key, winner_data
  );
endinterface

// File: rtl/binary_aggregator_pipe.sv
// Pipelined min/max winner selection over CANDIDATE_CNT candidates with round handshake.
// Optional BINARY_AGG_SKID_EN adds a 2-entry skid after the tree that cuts out_ready from in_ready.
module binary_aggregator_pipe #(
  parameter int CANDIDATE_CNT = 5,
  parameter int KEY_WIDTH     = 6,
  parameter int DATA_WIDTH    = 16,
  parameter int LV_PER_STAGE  = 1,
  parameter int MODE          = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  binary_aggregator_pipe_if.slave  bus
);
  localparam int LEVEL_CNT = $clog2(CANDIDATE_CNT);
  localparam int IDX_W     = (LEVEL_CNT > 1) ? LEVEL_CNT : 1;
  localparam int LEAVES    = 1 << LEVEL_CNT;
  localparam int LV_DIV    = (LV_PER_STAGE > 0) ? LV_PER_STAGE : 1;

  typedef struct packed {
    logic                  vld;
    logic [IDX_W-1:0]      idx;
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
  } node_t;

  localparam node_t NODE_NONE = '0;

  // Right input wins only when strictly better, so equal keys keep the lower index.
  function automatic node_t node_pick(input node_t l, input node_t r);
    node_t w;
    if (l.vld && r.vld) begin
      if (MODE != 0) w = (r.key > l.key) ? r : l;
      else           w = (r.key < l.key) ? r : l;
    end else if (l.vld) begin
      w = l;
    end else if (r.vld) begin
      w = r;
    end else begin
      w = NODE_NONE;
    end
    return w;
  endfunction

  node_t leaf_s [LEAVES];
  logic  pipe_rdy_s;
  logic  out_vld_s;
  node_t win_s;

  for (genvar i = 0; i < LEAVES; i++) begin : g_leaf
    if (i < CANDIDATE_CNT) begin : g_real
      assign leaf_s[i] = '{vld:  bus.candidate_vld[i],
                           idx:  IDX_W'(i),
                           key:  bus.candidate_key[i],
                           data: bus.candidate_data[i]};
    end else begin : g_pad
      assign leaf_s[i] = NODE_NONE;
    end
  end

  for (genvar c = 0; c < LEVEL_CNT; c++) begin : g_lvl
    localparam int N   = LEAVES >> (c + 1);
    localparam bit REG = (LV_PER_STAGE > 0) && (((LEVEL_CNT - 1 - c) % LV_DIV) == 0);

    node_t src_s [2*N];
    node_t cmp_s [N];
    node_t nd_s  [N];
    logic  src_rv_s;
    logic  rv_s;
    logic  down_rdy_s;
    logic  rdy_s;

    if (c == 0) begin : g_src
      assign src_s    = leaf_s;
      assign src_rv_s = bus.in_vld;
    end else begin : g_src
      assign src_s    = g_lvl[c-1].nd_s;
      assign src_rv_s = g_lvl[c-1].rv_s;
    end

    if (c == LEVEL_CNT - 1) begin : g_dn
      assign down_rdy_s = pipe_rdy_s;
    end else begin : g_dn
      assign down_rdy_s = g_lvl[c+1].rdy_s;
    end

    // One comparator level: pairwise winners of the level below.
    always_comb begin
      for (int j = 0; j < N; j++) begin
        cmp_s[j] = node_pick(src_s[2*j], src_s[2*j+1]);
      end
    end

    if (REG) begin : g_reg
      node_t nd_r [N];
      logic  rv_r;

      assign rdy_s = !rv_r || down_rdy_s;
      assign nd_s  = nd_r;
      assign rv_s  = rv_r;

      // Stage register: loads when empty or draining, so bubbles collapse.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rv_r <= 1'b0;
          for (int j = 0; j < N; j++) nd_r[j] <= NODE_NONE;
        end else begin
          if (rdy_s) rv_r <= src_rv_s;
          if (rdy_s && src_rv_s) nd_r <= cmp_s;
        end
      end
    end else begin : g_comb
      assign rdy_s = down_rdy_s;
      assign nd_s  = cmp_s;
      assign rv_s  = src_rv_s;
    end
  end

  node_t pipe_s;
  logic  pipe_vld_s;

  assign pipe_s       = g_lvl[LEVEL_CNT-1].nd_s[0];
  assign pipe_vld_s   = g_lvl[LEVEL_CNT-1].rv_s;
  assign bus.in_ready = g_lvl[0].rdy_s;

`ifdef BINARY_AGG_SKID_EN
  node_t      skid_r [2];
  logic [1:0] skid_cnt_r;
  logic       skid_rd_r;
  logic       skid_wr_r;
  logic       push_s;
  logic       pop_s;

  assign pipe_rdy_s = (skid_cnt_r != 2'd2);

  // An empty skid passes the tree output straight through; otherwise it serves in order.
  always_comb begin
    push_s = 1'b0;
    pop_s  = 1'b0;
    if (skid_cnt_r == 2'd0) begin
      push_s = pipe_vld_s && !bus.out_ready;
      pop_s  = 1'b0;
    end else begin
      push_s = pipe_vld_s && pipe_rdy_s;
      pop_s  = bus.out_ready;
    end
  end

  // Skid storage and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_cnt_r <= 2'd0;
      skid_rd_r  <= 1'b0;
      skid_wr_r  <= 1'b0;
      skid_r[0]  <= NODE_NONE;
      skid_r[1]  <= NODE_NONE;
    end else begin
      if (push_s) begin
        skid_r[skid_wr_r] <= pipe_s;
        skid_wr_r         <= ~skid_wr_r;
      end
      if (pop_s) skid_rd_r <= ~skid_rd_r;
      skid_cnt_r <= skid_cnt_r + {1'b0, push_s} - {1'b0, pop_s};
    end
  end

  // Output select between skid head and tree output.
  always_comb begin
    out_vld_s = pipe_vld_s;
    win_s     = pipe_s;
    if (skid_cnt_r != 2'd0) begin
      out_vld_s = 1'b1;
      win_s     = skid_r[skid_rd_r];
    end else begin
      out_vld_s = pipe_vld_s;
      win_s     = pipe_s;
    end
  end
`else
  assign pipe_rdy_s = bus.out_ready;
  assign out_vld_s  = pipe_vld_s;
  assign win_s      = pipe_s;
`endif

  assign bus.out_vld     = out_vld_s;
  assign bus.winner_hit  = win_s.vld;
  assign bus.winner_idx  = win_s.idx;
  assign bus.winner_key  = win_s.key;
  assign bus.winner_data = win_s.data;
endmodule
